occupancy_arbiter: RTL and testbench
====================================

Name: occupancy_arbiter

Overview:
- Shares a single room-occupancy counter between N_DOORS door-sensor FSM instances. Each instance emits one-cycle entered/exited pulses.
- Per-door pending flags latch the pulses. A round-robin arbiter services one event per cycle, so simultaneous events from different doors are never dropped.
- Drives the capacity flags (full/empty) consumed by the door lock and display logic, plus sticky error flags for status readout.

Parameters:
- N_DOORS, 4, number of door FSMs (requesters); 2..8.
- CAP, 15, maximum occupancy; must satisfy CAP < 2**CNT_W.
- CNT_W, 4, occupancy counter width.
- IDX_W, 2, grant index width; must equal clog2(N_DOORS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of counter, pending flags, pointer and errors.
- entered  in  N_DOORS  one-cycle entry pulse per door.
- exited  in  N_DOORS  one-cycle exit pulse per door.
- occupancy  out  CNT_W  current occupancy count.
- full  out  1  occupancy == CAP.
- empty  out  1  occupancy == 0.
- grant_valid  out  1  one-cycle strobe: an event was applied this cycle.
- grant_door  out  IDX_W  door index of the applied event.
- grant_dir  out  1  direction of the applied event: 1 = entry, 0 = exit.
- reject_err  out  1  sticky: an entry arrived while full and was discarded.
- underflow_err  out  1  sticky: an exit arrived while empty and was discarded.
- overrun_err  out  1  sticky: a pulse arrived while that door's same-direction pending flag was already set.

Behaviour:
- Reset (reset = 0, async):
  - occupancy = 0, empty = 1, full = 0.
  - grant_valid = 0, grant_door = 0, grant_dir = 0.
  - All pending flags cleared; all sticky errors = 0; RR pointer = 0.
- clear = 1 (sync): same values as reset at the next edge. clear has priority over pulses arriving in the same cycle; those pulses are dropped.
- Pending latch:
  - pend_in[i] is set at the edge after entered[i] = 1; pend_out[i] likewise from exited[i].
  - If a pulse arrives in the same cycle its flag is being serviced, the flag stays set. The new event wins.
  - A pulse to an already-set flag that is not being serviced that cycle is lost and sets overrun_err.
- FSM states:
  - IDLE: no pending flags. Go to SERVE when any flag is set.
  - SERVE: one event applied per cycle. Return to IDLE when no flags remain after this cycle's service.
- Arbitration:
  - Search doors starting at the RR pointer, wrapping modulo N_DOORS. Pick the first door with any pending flag.
  - If that door has both flags set, the exit is serviced first; the entry stays pending for a later turn.
  - The pointer moves to the granted door + 1 (wrapping) only after that door has no flags left. Both events of a door are therefore serviced in consecutive cycles.
- Counter update (registered, in the SERVE cycle):
  - Exit with occupancy > 0: decrement.
  - Exit with occupancy == 0: no change; set underflow_err.
  - Entry with occupancy < CAP: increment.
  - Entry with occupancy == CAP: no change; set reject_err.
  - In all four cases the serviced flag clears and grant_valid pulses with grant_door/grant_dir.
- Latency: a pulse sampled at edge E0 sets its flag at E0. With no contention, occupancy and grant_valid update at E1, i.e. visible one cycle after the pulse is sampled. Each additional contending event adds 1 cycle.
- full and empty are combinational from the occupancy register.
- Sticky errors clear only on reset or clear.

Optional Feature:
- Macro: OCC_PEAK_EN.
- Defined:
  - Adds output port peak_occ [CNT_W], reset 0, cleared by clear.
  - peak_occ updates to the new occupancy whenever an increment makes occupancy > peak_occ, in the same cycle as the increment.
- Undefined: port and register absent; all other behaviour unchanged.

Test Plan:
- Reset/idle: hold reset = 0 for 2 cycles, then release -> occupancy = 0, empty = 1, full = 0, all errors = 0, grant_valid never asserted while idle.
- Simultaneous entries: entered = 4'b1011 in one cycle -> grants to doors 0, 1, 3 on 3 consecutive cycles, grant_dir = 1 each, occupancy 1, 2, 3, then FSM returns to IDLE.
- Round-robin fairness:
  - After a grant to door 1, pulse entered[0] and entered[2] together -> door 2 granted before door 0.
  - Same-door entry+exit at occupancy 2 -> exit granted first (occupancy 1), then entry (occupancy 2).
- Capacity boundary (CAP = 3): 4 serial entries -> occupancy 3, full = 1, reject_err = 1, grant_valid still pulses for the 4th entry.
- Underflow and overrun:
  - exited[2] at occupancy 0 -> underflow_err = 1, occupancy stays 0.
  - Two entered[1] pulses while door 1 is blocked behind door 0 -> overrun_err = 1.
- Clear/reset mid-operation:
  - clear asserted with 3 events pending -> next cycle all flags empty, occupancy 0, errors 0, no further grants.
  - With OCC_PEAK_EN defined: peak_occ = 3 after the capacity test; 0 after clear.

Source files
------------

// File: rtl/occupancy_arbiter.sv
// Round-robin arbiter sharing one occupancy counter between N_DOORS door FSMs; optional peak tracker via OCC_PEAK_EN.
// Latency: a pulse sampled at edge E0 is applied at E1 when uncontended; each contending event adds one cycle.
// Backpressure: none; pulses latch into per-door pending flags, and a pulse hitting an unserviced set flag is lost and raises overrun_err.
module occupancy_arbiter #(
  parameter int N_DOORS = 4,
  parameter int CAP     = 15,
  parameter int CNT_W   = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [N_DOORS-1:0] entered,
  input  logic [N_DOORS-1:0] exited,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_door,
  output logic               grant_dir,
  output logic               reject_err,
  output logic               underflow_err,
  output logic               overrun_err
`ifdef OCC_PEAK_EN
  ,
  output logic [CNT_W-1:0]   peak_occ
`endif
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t             state_q, state_d;
  logic [N_DOORS-1:0] pend_in_q, pend_out_q, pend_in_d, pend_out_d, req;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, sel;
  logic               found, serve, sel_dir, ovr_d, any_d;
  logic               inc, dec, rej, und;
  logic [CNT_W-1:0]   occ_inc;
  int                 j;

  assign req     = pend_in_q | pend_out_q;
  assign full    = (occupancy == CNT_W'(CAP));
  assign empty   = (occupancy == '0);
  assign occ_inc = occupancy + 1'b1;

  // First requesting door at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < N_DOORS; k++) begin
      j = (int'(rr_ptr_q) + k) % N_DOORS;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
  end

  assign serve   = (state_q == SERVE) && found;
  assign sel_dir = ~pend_out_q[sel];
  assign inc     = serve &&  sel_dir && (occupancy != CNT_W'(CAP));
  assign rej     = serve &&  sel_dir && (occupancy == CNT_W'(CAP));
  assign dec     = serve && !sel_dir && (occupancy != '0);
  assign und     = serve && !sel_dir && (occupancy == '0);

  always_comb begin
    pend_in_d  = pend_in_q;
    pend_out_d = pend_out_q;
    if (serve) begin
      if (sel_dir) pend_in_d[sel]  = 1'b0;
      else         pend_out_d[sel] = 1'b0;
    end
    // Serviced flag is already cleared here, so a same-cycle pulse re-arms it without overrun.
    ovr_d      = |((entered & pend_in_d) | (exited & pend_out_d));
    pend_in_d  = pend_in_d | entered;
    pend_out_d = pend_out_d | exited;
    any_d      = |(pend_in_d | pend_out_d);

    rr_ptr_d = rr_ptr_q;
    if (serve && !pend_in_d[sel] && !pend_out_d[sel])
      rr_ptr_d = IDX_W'((int'(sel) + 1) % N_DOORS);

    state_d = state_q;
    case (state_q)
      IDLE:    if (any_d)  state_d = SERVE;
      SERVE:   if (!any_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pend_in_q     <= '0;
      pend_out_q    <= '0;
      rr_ptr_q      <= '0;
      occupancy     <= '0;
      grant_valid   <= 1'b0;
      grant_door    <= '0;
      grant_dir     <= 1'b0;
      reject_err    <= 1'b0;
      underflow_err <= 1'b0;
      overrun_err   <= 1'b0;
    end else if (clear) begin
      state_q       <= IDLE;
      pend_in_q     <= '0;
      pend_out_q    <= '0;
      rr_ptr_q      <= '0;
      occupancy     <= '0;
      grant_valid   <= 1'b0;
      grant_door    <= '0;
      grant_dir     <= 1'b0;
      reject_err    <= 1'b0;
      underflow_err <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_in_q   <= pend_in_d;
      pend_out_q  <= pend_out_d;
      rr_ptr_q    <= rr_ptr_d;
      if (inc)      occupancy <= occ_inc;
      else if (dec) occupancy <= occupancy - 1'b1;
      grant_valid   <= serve;
      grant_door    <= serve ? sel : '0;
      grant_dir     <= serve & sel_dir;
      reject_err    <= reject_err | rej;
      underflow_err <= underflow_err | und;
      overrun_err   <= overrun_err | ovr_d;
    end
  end

`ifdef OCC_PEAK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         peak_occ <= '0;
    else if (clear)                     peak_occ <= '0;
    else if (inc && occ_inc > peak_occ) peak_occ <= occ_inc;
  end
`endif

endmodule

// File: tb/tb_occupancy_arbiter.sv
// Scoreboard bench for occupancy_arbiter (CAP=3): a per-cycle reference model queues expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_occupancy_arbiter;
  localparam int N   = 4;
  localparam int CAP = 3;
  localparam int CW  = 4;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          reset, clear;
  logic [N-1:0]  entered, exited;
  logic [CW-1:0] occupancy;
  logic          full, empty, grant_valid, grant_dir;
  logic [IW-1:0] grant_door;
  logic          reject_err, underflow_err, overrun_err;
`ifdef OCC_PEAK_EN
  logic [CW-1:0] peak_occ;
`endif

  occupancy_arbiter #(.N_DOORS(N), .CAP(CAP), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .entered(entered), .exited(exited),
    .occupancy(occupancy), .full(full), .empty(empty), .grant_valid(grant_valid),
    .grant_door(grant_door), .grant_dir(grant_dir), .reject_err(reject_err),
    .underflow_err(underflow_err), .overrun_err(overrun_err)
`ifdef OCC_PEAK_EN
    , .peak_occ(peak_occ)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit gv;
    int door;
    bit dir;
    int occ;
    bit rej, und, ovr;
    int peak;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  // Reference state: pending events per door, pointer, count, sticky flags.
  bit   m_in[N], m_out[N];
  int   m_ptr, m_occ, m_peak;
  bit   m_rej, m_und, m_ovr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_in[i] = 0; m_out[i] = 0; end
    m_ptr = 0; m_occ = 0; m_peak = 0; m_rej = 0; m_und = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit clr, input logic [N-1:0] ent, input logic [N-1:0] ext);
    exp_t e;
    int   d;
    bit   dir, got;
    e = '{cyc: cyc + 1, gv: 0, door: 0, dir: 0, occ: 0, rej: 0, und: 0, ovr: 0, peak: 0};
    if (clr) begin
      model_reset();
    end else begin
      got = 0; d = 0; dir = 0;
      for (int k = 0; k < N; k++)
        if (!got && (m_in[(m_ptr + k) % N] || m_out[(m_ptr + k) % N])) begin
          got = 1; d = (m_ptr + k) % N;
        end
      if (got) begin
        dir = !m_out[d];
        if (!dir) begin
          if (m_occ > 0) m_occ--; else m_und = 1;
          m_out[d] = 0;
        end else begin
          if (m_occ < CAP) begin
            m_occ++;
            if (m_occ > m_peak) m_peak = m_occ;
          end else m_rej = 1;
          m_in[d] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ent[i]) begin if (m_in[i])  m_ovr = 1; m_in[i]  = 1; end
        if (ext[i]) begin if (m_out[i]) m_ovr = 1; m_out[i] = 1; end
      end
      if (got && !m_in[d] && !m_out[d]) m_ptr = (d + 1) % N;
      e.gv = got; e.door = got ? d : 0; e.dir = got && dir;
    end
    e.occ = m_occ; e.rej = m_rej; e.und = m_und; e.ovr = m_ovr; e.peak = m_peak;
    sb.push_back(e);
  endtask

  task automatic drive(input bit clr, input logic [N-1:0] ent, input logic [N-1:0] ext);
    @(negedge clk);
    clear = clr; entered = ent; exited = ext;
    model_step(clr, ent, ext);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  // Monitor: compare the record expected for the edge just passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (grant_valid !== e.gv || grant_door !== IW'(e.door) || grant_dir !== e.dir) begin
          n_bad++;
          $display("FAIL grant cyc=%0d got v=%0b door=%0d dir=%0b want v=%0b door=%0d dir=%0b",
                   cyc, grant_valid, grant_door, grant_dir, e.gv, e.door, e.dir);
        end
        n_cmp++;
        if (occupancy !== CW'(e.occ) || full !== (e.occ == CAP) || empty !== (e.occ == 0) ||
            reject_err !== e.rej || underflow_err !== e.und || overrun_err !== e.ovr) begin
          n_bad++;
          $display("FAIL status cyc=%0d got occ=%0d f=%0b e=%0b rej=%0b und=%0b ovr=%0b want occ=%0d rej=%0b und=%0b ovr=%0b",
                   cyc, occupancy, full, empty, reject_err, underflow_err, overrun_err,
                   e.occ, e.rej, e.und, e.ovr);
        end
`ifdef OCC_PEAK_EN
        n_cmp++;
        if (peak_occ !== CW'(e.peak)) begin
          n_bad++;
          $display("FAIL peak cyc=%0d got %0d want %0d", cyc, peak_occ, e.peak);
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; entered = '0; exited = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (occupancy !== '0 || empty !== 1'b1 || full !== 1'b0 || grant_valid !== 1'b0 ||
        reject_err !== 1'b0 || underflow_err !== 1'b0 || overrun_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset got occ=%0d e=%0b f=%0b gv=%0b errs=%0b%0b%0b want 0 1 0 0 000",
               occupancy, empty, full, grant_valid, reject_err, underflow_err, overrun_err);
    end
    reset = 1'b1;
    idle(3);
    // Three simultaneous entries: doors 0,1,3 in order, reaching full.
    drive(0, 4'b1011, 4'b0000); idle(5);
    // Fairness: after door 1, door 2 beats door 0.
    drive(1, '0, '0);
    drive(0, 4'b0010, 4'b0000); idle(3);
    drive(0, 4'b0101, 4'b0000); idle(4);
    // Same-door entry+exit at occupancy 2: exit first.
    drive(1, '0, '0);
    drive(0, 4'b0011, 4'b0000); idle(4);
    drive(0, 4'b0100, 4'b0100); idle(4);
    // Capacity: serial entries past CAP.
    drive(1, '0, '0);
    for (int i = 0; i < 4; i++) begin drive(0, 4'b1000, 4'b0000); idle(2); end
    drive(1, '0, '0);
    // Underflow.
    drive(0, 4'b0000, 4'b0100); idle(3);
    // Overrun: door 1 blocked behind door 0's two events.
    drive(1, '0, '0);
    drive(0, 4'b0011, 4'b0001);
    drive(0, 4'b0010, 4'b0000); idle(5);
    // Clear with events pending.
    drive(0, 4'b0111, 4'b0000);
    drive(1, '0, '0); idle(4);
    // Random traffic with occasional clear.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) == 0, N'($urandom & $urandom & $urandom),
            N'($urandom & $urandom & $urandom));
    idle(12);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d records left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
